// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory arbiter.
// Contents: RAM status encoding, arbiter FSM state encoding, and the
// default watchdog limit.
package mem_arb_pkg;

  // Status reported by the RAM model every cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    INSTR  = 3'd2,
    DONE_D = 3'd3,
    DONE_I = 3'd4,
    FAULT  = 3'd5
  } arb_state_t;

  // Default cycles allowed in DATA/INSTR before declaring a RAM fault.
  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle between the pipeline requesters, the arbiter and the RAM.
// Ports: fetch side (iREN/iaddr/iload/ihit), data side (dREN/dWEN/daddr/dstore/
// dload/dhit), RAM side (ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate), err.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              ihit;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dhit;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;

  logic              err;

  // Arbiter side.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
  );

  // Requester / RAM-model side.
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises data and instruction requests onto one variable-latency RAM.
// Ports: CLK, nRST (async active-low), bus (mem_arbiter_if.slave).
// Data beats fetch; hits are one-cycle registered pulses; err is sticky until reset.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  arb_state_t state;
  logic [7:0] wd_cnt;

  // Watchdog fires on the cycle that would bring the count up to the limit,
  // so exactly TIMEOUT cycles are spent waiting before FAULT.
  logic wd_expire;
  assign wd_expire = ((wd_cnt + 8'd1) == TIMEOUT_CNT);

  // All outputs are registered so hits and RAM enables are glitch-free and
  // drop asynchronously on reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= IDLE;
      wd_cnt       <= 8'd0;
      bus.ihit     <= 1'b0;
      bus.dhit     <= 1'b0;
      bus.err      <= 1'b0;
      bus.ramREN   <= 1'b0;
      bus.ramWEN   <= 1'b0;
      bus.iload    <= {DATA_W{1'b0}};
      bus.dload    <= {DATA_W{1'b0}};
      bus.ramaddr  <= {ADDR_W{1'b0}};
      bus.ramstore <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (bus.dREN || bus.dWEN) begin
            // dREN and dWEN together resolve to a write.
            state        <= DATA;
            wd_cnt       <= 8'd0;
            bus.ramaddr  <= bus.daddr;
            bus.ramstore <= bus.dstore;
            bus.ramWEN   <= bus.dWEN;
            bus.ramREN   <= ~bus.dWEN;
          end else if (bus.iREN) begin
            state       <= INSTR;
            wd_cnt      <= 8'd0;
            bus.ramaddr <= bus.iaddr;
            bus.ramREN  <= 1'b1;
            bus.ramWEN  <= 1'b0;
          end
        end

        DATA, INSTR: begin
          if (bus.ramstate == ACCESS) begin
            if (state == DATA) begin
              bus.dload <= bus.ramload;
              bus.dhit  <= 1'b1;
              state     <= DONE_D;
            end else begin
              bus.iload <= bus.ramload;
              bus.ihit  <= 1'b1;
              state     <= DONE_I;
            end
            bus.ramREN <= 1'b0;
            bus.ramWEN <= 1'b0;
          end else if (bus.ramstate == ERROR || wd_expire) begin
            state      <= FAULT;
            bus.err    <= 1'b1;
            bus.ramREN <= 1'b0;
            bus.ramWEN <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end

        DONE_D: begin
          bus.dhit <= 1'b0;
          state    <= IDLE;
        end

        DONE_I: begin
          bus.ihit <= 1'b0;
          state    <= IDLE;
        end

        FAULT: begin
          // Terminal until reset.
          bus.err    <= 1'b1;
          bus.ramREN <= 1'b0;
          bus.ramWEN <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          bus.ramREN <= 1'b0;
          bus.ramWEN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic CLK;
  logic nRST;
  int   tests;
  int   fails;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    bus.iREN     = 1'b0;
    bus.iaddr    = 32'h0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = 32'h0;
    bus.dstore   = 32'h0;
    bus.ramload  = 32'h0;
    bus.ramstate = FREE;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    @(negedge CLK);
    tests++;
    if ({bus.ihit, bus.dhit, bus.err, bus.ramREN, bus.ramWEN} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 00000",
               {bus.ihit, bus.dhit, bus.err, bus.ramREN, bus.ramWEN});
    end
    tests++;
    if ({bus.iload, bus.dload, bus.ramaddr, bus.ramstore} !== 128'h0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0",
               {bus.iload, bus.dload, bus.ramaddr, bus.ramstore});
    end
    nRST = 1'b1;
  endtask

  // Data read with RAM latency 3.
  task automatic test_data_read();
    @(negedge CLK);
    bus.dREN  = 1'b1;
    bus.daddr = 32'h0000_0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      tests++;
      if ({bus.ramREN, bus.ramWEN, bus.dhit} !== 3'b100) begin
        fails++;
        $display("FAIL rd_wait%0d: ren/wen/dhit got %b want 100", i,
                 {bus.ramREN, bus.ramWEN, bus.dhit});
      end
      bus.ramstate = (i == 2) ? ACCESS : BUSY;
      bus.ramload  = 32'hDEAD_BEEF;
    end
    tests++;
    if (bus.ramaddr !== 32'h10) begin
      fails++;
      $display("FAIL rd_addr: got %h want 00000010", bus.ramaddr);
    end
    @(negedge CLK);
    tests++;
    if ({bus.dhit, bus.ihit, bus.ramREN} !== 3'b100 || bus.dload !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL rd_hit: dhit/ihit/ren %b dload %h want 100 deadbeef",
               {bus.dhit, bus.ihit, bus.ramREN}, bus.dload);
    end
    bus.dREN     = 1'b0;
    bus.ramstate = FREE;
    @(negedge CLK);
    tests++;
    if ({bus.dhit, bus.ihit, bus.ramREN} !== 3'b000) begin
      fails++;
      $display("FAIL rd_after: dhit/ihit/ren got %b want 000",
               {bus.dhit, bus.ihit, bus.ramREN});
    end
  endtask

  // Write and fetch raised together: write first, fetch after one IDLE cycle.
  task automatic test_back_to_back();
    @(negedge CLK);
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h40;
    bus.dstore = 32'h1234;
    bus.iREN   = 1'b1;
    bus.iaddr  = 32'h100;
    @(negedge CLK);
    tests++;
    if ({bus.ramWEN, bus.ramREN} !== 2'b10 || bus.ramaddr !== 32'h40 ||
        bus.ramstore !== 32'h1234) begin
      fails++;
      $display("FAIL b2b_write: wen/ren %b addr %h store %h want 10 40 1234",
               {bus.ramWEN, bus.ramREN}, bus.ramaddr, bus.ramstore);
    end
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h5555_AAAA;
    @(negedge CLK);
    tests++;
    if ({bus.dhit, bus.ihit, bus.ramWEN, bus.ramREN} !== 4'b1000) begin
      fails++;
      $display("FAIL b2b_dhit: dhit/ihit/wen/ren got %b want 1000",
               {bus.dhit, bus.ihit, bus.ramWEN, bus.ramREN});
    end
    bus.dWEN = 1'b0;
    @(negedge CLK);
    // IDLE cycle: ACCESS still on the bus must be ignored here.
    tests++;
    if ({bus.dhit, bus.ihit, bus.ramWEN, bus.ramREN} !== 4'b0000) begin
      fails++;
      $display("FAIL b2b_idle: dhit/ihit/wen/ren got %b want 0000",
               {bus.dhit, bus.ihit, bus.ramWEN, bus.ramREN});
    end
    bus.ramstate = FREE;
    @(negedge CLK);
    tests++;
    if ({bus.ramREN, bus.ramWEN} !== 2'b10 || bus.ramaddr !== 32'h100) begin
      fails++;
      $display("FAIL b2b_fetch: ren/wen %b addr %h want 10 00000100",
               {bus.ramREN, bus.ramWEN}, bus.ramaddr);
    end
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hCAFE_0001;
    @(negedge CLK);
    tests++;
    if ({bus.ihit, bus.dhit} !== 2'b10 || bus.iload !== 32'hCAFE_0001) begin
      fails++;
      $display("FAIL b2b_ihit: ihit/dhit %b iload %h want 10 cafe0001",
               {bus.ihit, bus.dhit}, bus.iload);
    end
    bus.iREN     = 1'b0;
    bus.ramstate = FREE;
    @(negedge CLK);
    tests++;
    if ({bus.ihit, bus.dhit, bus.ramREN} !== 3'b000) begin
      fails++;
      $display("FAIL b2b_end: ihit/dhit/ren got %b want 000",
               {bus.ihit, bus.dhit, bus.ramREN});
    end
  endtask

  task automatic test_rw_both();
    @(negedge CLK);
    bus.dREN   = 1'b1;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h80;
    bus.dstore = 32'h0BAD_F00D;
    @(negedge CLK);
    tests++;
    if ({bus.ramWEN, bus.ramREN} !== 2'b10 || bus.ramstore !== 32'h0BAD_F00D) begin
      fails++;
      $display("FAIL rw_both: wen/ren %b store %h want 10 0badf00d",
               {bus.ramWEN, bus.ramREN}, bus.ramstore);
    end
    bus.ramstate = ACCESS;
    @(negedge CLK);
    tests++;
    if (bus.dhit !== 1'b1) begin
      fails++;
      $display("FAIL rw_hit: dhit got %b want 1", bus.dhit);
    end
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.ramstate = FREE;
    @(negedge CLK);
  endtask

  // RAM stays BUSY: with TIMEOUT=4, four DATA cycles then FAULT.
  task automatic test_timeout();
    @(negedge CLK);
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h20;
    bus.ramstate = BUSY;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      tests++;
      if ({bus.ramREN, bus.err} !== 2'b10) begin
        fails++;
        $display("FAIL to_wait%0d: ren/err got %b want 10", i, {bus.ramREN, bus.err});
      end
    end
    @(negedge CLK);
    tests++;
    if ({bus.err, bus.ramREN, bus.ramWEN, bus.dhit} !== 4'b1000) begin
      fails++;
      $display("FAIL to_fault: err/ren/wen/dhit got %b want 1000",
               {bus.err, bus.ramREN, bus.ramWEN, bus.dhit});
    end
    bus.dREN     = 1'b0;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h200;
    bus.ramstate = ACCESS;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      tests++;
      if ({bus.err, bus.ramREN, bus.ihit, bus.dhit} !== 4'b1000) begin
        fails++;
        $display("FAIL to_sticky%0d: err/ren/ihit/dhit got %b want 1000", i,
                 {bus.err, bus.ramREN, bus.ihit, bus.dhit});
      end
    end
    idle_inputs();
    pulse_reset();
    tests++;
    if (bus.err !== 1'b0) begin
      fails++;
      $display("FAIL to_clear: err got %b want 0", bus.err);
    end
  endtask

  task automatic test_ram_error();
    @(negedge CLK);
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h300;
    @(negedge CLK);
    tests++;
    if ({bus.ramREN, bus.err} !== 2'b10) begin
      fails++;
      $display("FAIL er_instr: ren/err got %b want 10", {bus.ramREN, bus.err});
    end
    bus.ramstate = ERROR;
    @(negedge CLK);
    tests++;
    if ({bus.err, bus.ramREN, bus.ihit} !== 3'b100) begin
      fails++;
      $display("FAIL er_fault: err/ren/ihit got %b want 100",
               {bus.err, bus.ramREN, bus.ihit});
    end
    idle_inputs();
    pulse_reset();
  endtask

  // Reset mid-access, then a fetch held through reset completes normally.
  task automatic test_reset_mid();
    @(negedge CLK);
    bus.dREN     = 1'b1;
    bus.daddr    = 32'h44;
    bus.ramstate = BUSY;
    @(negedge CLK);
    @(negedge CLK);
    tests++;
    if (bus.ramREN !== 1'b1) begin
      fails++;
      $display("FAIL rm_pre: ren got %b want 1", bus.ramREN);
    end
    #1;
    nRST         = 1'b0;
    bus.dREN     = 1'b0;
    bus.iREN     = 1'b1;
    bus.iaddr    = 32'h400;
    bus.ramstate = FREE;
    #1;
    tests++;
    if ({bus.ramREN, bus.ramWEN, bus.dhit, bus.ihit, bus.err} !== 5'b0 ||
        {bus.ramaddr, bus.dload, bus.iload, bus.ramstore} !== 128'h0) begin
      fails++;
      $display("FAIL rm_async: flags %b data %h want 0",
               {bus.ramREN, bus.ramWEN, bus.dhit, bus.ihit, bus.err},
               {bus.ramaddr, bus.dload, bus.iload, bus.ramstore});
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    tests++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h400) begin
      fails++;
      $display("FAIL rm_fetch: ren %b addr %h want 1 00000400", bus.ramREN, bus.ramaddr);
    end
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h1357_9BDF;
    @(negedge CLK);
    tests++;
    if (bus.ihit !== 1'b1 || bus.iload !== 32'h1357_9BDF) begin
      fails++;
      $display("FAIL rm_ihit: ihit %b iload %h want 1 13579bdf", bus.ihit, bus.iload);
    end
    idle_inputs();
    @(negedge CLK);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_data_read();
    test_back_to_back();
    test_rw_both();
    test_timeout();
    test_ram_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
